sysbus_mem_responder: RTL and testbench

SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

---
 rtl/sysbus_mem_responder.sv | 129 ++++++++++++
 tb/tb_sysbus_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// System-bus memory target: one outstanding request, 8-beat line bursts for
// reads and writes, fixed read latency, backing store loadable hierarchically.
module sysbus_mem_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqcyc,
    input  logic [63:0] req,
    input  logic [12:0] reqtag,
    output logic        reqack,
    output logic        respcyc,
    output logic [63:0] resp,
    output logic [12:0] resptag,
    input  logic        respack
);

    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int LINE_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACK   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] TYPE_MEMORY = 4'h1;

    logic [2:0]        r_state;
    logic [LINE_W-1:0] r_line;
    logic [12:0]       r_tag;
    logic [2:0]        r_beat;
    logic [3:0]        r_count;
    logic [63:0]       r_mem [MEM_WORDS];

    logic              w_is_read;
    logic              w_is_mem;
    logic              w_mem_we;
    logic [LINE_W+2:0] w_word;
    logic [ADDR_W-1:0] w_idx;

    assign w_is_read = r_tag[12];
    assign w_is_mem  = (r_tag[11:8] == TYPE_MEMORY);

    // Only the line bits that land inside the store are kept, so higher
    // address bits wrap modulo the store depth for free.
    assign w_word = {r_line, r_beat};
    assign w_idx  = w_word[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_line  <= '0;
            r_tag   <= '0;
            r_beat  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reqcyc) begin
                        r_line  <= req[6 +: LINE_W];
                        r_tag   <= reqtag;
                        r_beat  <= '0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_beat <= '0;
                    if (w_is_read) begin
                        r_count <= 4'(LATENCY);
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    r_beat <= r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Leaving on the count of one gives exactly LATENCY wait cycles.
                    r_count <= (r_count == 4'd0) ? 4'd0 : r_count - 4'd1;
                    if (r_count <= 4'd1) begin
                        r_beat  <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (respack) begin
                        if (r_beat == 3'd7) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Store is never reset; non-memory writes are consumed but dropped.
    assign w_mem_we = (r_state == S_WDATA) && w_is_mem;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= req;
        end
    end

    always_comb begin
        reqack  = (r_state == S_ACK);
        respcyc = 1'b0;
        resp    = '0;
        resptag = '0;
        if (r_state == S_RESP) begin
            respcyc = 1'b1;
            resptag = r_tag;
            resp    = w_is_mem ? r_mem[w_idx] : 64'h0;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomised scoreboard bench for sysbus_mem_responder: a driver issues bus
// transactions against a flat memory model, a monitor checks every response beat.
module tb_sysbus_mem_responder;

    localparam int MEM_WORDS = 4096;
    localparam int LATENCY   = 4;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
        int          beat;
        int          firstCycle;
    } exp_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        reqcyc  = 1'b0;
    logic [63:0] req     = '0;
    logic [12:0] reqtag  = '0;
    logic        respack = 1'b1;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;

    exp_t        sbq[$];
    logic [63:0] model [MEM_WORDS];
    int          vectors      = 0;
    int          miscompares  = 0;
    int          cycleCount   = 0;
    int          holdCount    = 0;
    int          beat2Hold    = 0;
    int          stallLeft    = 0;
    bit          firstChecked = 0;
    bit          stallMode    = 0;
    bit          randomAck    = 0;

    sysbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk     (clk),
        .reset   (reset),
        .reqcyc  (reqcyc),
        .req     (req),
        .reqtag  (reqtag),
        .reqack  (reqack),
        .respcyc (respcyc),
        .resp    (resp),
        .resptag (resptag),
        .respack (respack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Response acceptance: either a scripted 3-cycle stall on beat 2, random, or always ready.
    always @(posedge clk) begin
        #1;
        if (stallMode && respcyc && sbq.size() > 0 && sbq[0].beat == 2 && stallLeft > 0) begin
            respack = 1'b0;
            stallLeft--;
        end else if (randomAck) begin
            respack = ($urandom_range(0, 3) != 0);
        end else begin
            respack = 1'b1;
        end
    end

    // Monitor: every presented beat must match the head of the scoreboard and
    // stay put until accepted; the first beat of a burst must arrive on time.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && respcyc) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_respcyc actual=1 expected=0 at cycle %0d", cycleCount);
            end else begin
                e = sbq[0];
                if (!firstChecked && e.firstCycle >= 0) begin
                    checkOutput("first_beat_cycle", 64'(cycleCount), 64'(e.firstCycle));
                    firstChecked = 1;
                end
                checkOutput($sformatf("resp_beat%0d", e.beat), resp, e.data);
                checkOutput($sformatf("resptag_beat%0d", e.beat), 64'(resptag), 64'(e.tag));
                holdCount++;
                if (respack) begin
                    if (e.beat == 2) beat2Hold = holdCount;
                    holdCount    = 0;
                    firstChecked = 0;
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // One bus transaction; reads may be cut short by a reset on a chosen beat.
    task automatic applyStimulus(input bit isRead, input logic [3:0] typ, input logic [63:0] addr,
                                 input logic [7:0] itag, input logic [7:0][63:0] wdata, input int abortAtBeat);
        logic [12:0]     tag;
        longint unsigned line;
        int              waited;
        exp_t            e;
        tag    = {isRead, typ, itag};
        line   = addr >> 6;
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!reqack && waited < 10);
        reqcyc = 1'b0;
        checkOutput("ack_latency", 64'(waited), 64'd2);
        if (!reqack) return;

        if (isRead) begin
            for (int k = 0; k < 8; k++) begin
                e.data       = (typ == 4'h1) ? model[int'((line * 8 + longint'(k)) % MEM_WORDS)] : 64'h0;
                e.tag        = tag;
                e.beat       = k;
                e.firstCycle = (k == 0) ? cycleCount + LATENCY + 1 : -1;
                sbq.push_back(e);
            end
            @(negedge clk);
            checkOutput("ack_pulse", 64'(reqack), 64'd0);
            waited = 0;
            while (sbq.size() != 0 && waited < 200) begin
                @(negedge clk);
                #2;
                waited++;
                if (abortAtBeat >= 0 && sbq.size() > 0 && sbq[0].beat == abortAtBeat) begin
                    @(posedge clk);
                    #2;
                    checkOutput("pre_reset_respcyc", 64'(respcyc), 64'd1);
                    checkOutput("pre_reset_resp", resp, sbq[0].data);
                    reset = 1'b1;
                    #1;
                    checkOutput("abort_respcyc", 64'(respcyc), 64'd0);
                    checkOutput("abort_resp", resp, 64'd0);
                    checkOutput("abort_resptag", 64'(resptag), 64'd0);
                    sbq.delete();
                    holdCount    = 0;
                    firstChecked = 0;
                    repeat (2) @(posedge clk);
                    #1;
                    reset = 1'b0;
                end
            end
            if (sbq.size() != 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL read_timeout actual=%0d expected=0 beats outstanding", sbq.size());
                sbq.delete();
            end
        end else begin
            @(negedge clk);
            checkOutput("ack_pulse", 64'(reqack), 64'd0);
            req = wdata[0];
            for (int k = 1; k < 8; k++) begin
                @(posedge clk);
                #1;
                req = wdata[k];
            end
            @(posedge clk);
            #1;
            if (typ == 4'h1) begin
                for (int k = 0; k < 8; k++) begin
                    model[int'((line * 8 + longint'(k)) % MEM_WORDS)] = wdata[k];
                end
            end
        end
    endtask

    initial begin
        logic [7:0][63:0] wd;
        logic [63:0]      addr;
        logic [3:0]       typ;

        for (int i = 0; i < MEM_WORDS; i++) begin
            model[i]     = {$urandom, $urandom};
            dut.r_mem[i] = model[i];
        end
        for (int k = 0; k < 8; k++) begin
            model[8 + k]     = 64'h1000 + 64'(k);
            dut.r_mem[8 + k] = model[8 + k];
        end

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_reqack", 64'(reqack), 64'd0);
        checkOutput("reset_respcyc", 64'(respcyc), 64'd0);
        checkOutput("reset_resp", resp, 64'd0);
        checkOutput("reset_resptag", 64'(resptag), 64'd0);
        reset = 1'b0;

        wd = '0;
        applyStimulus(1'b1, 4'h1, 64'h48, 8'h00, wd, -1);

        stallMode = 1;
        stallLeft = 3;
        applyStimulus(1'b1, 4'h1, 64'h48, 8'h00, wd, -1);
        checkOutput("beat2_hold_cycles", 64'(beat2Hold), 64'd4);
        stallMode = 0;

        for (int k = 0; k < 8; k++) wd[k] = 64'hA0 + 64'(k);
        applyStimulus(1'b0, 4'h1, 64'h80, 8'h00, wd, -1);
        applyStimulus(1'b1, 4'h1, 64'h80, 8'h00, wd, -1);

        applyStimulus(1'b1, 4'h1, 64'h8000, 8'h00, wd, -1);
        applyStimulus(1'b1, 4'h2, 64'h48, 8'h00, wd, -1);

        applyStimulus(1'b1, 4'h1, 64'h48, 8'h00, wd, 3);
        applyStimulus(1'b1, 4'h1, 64'h48, 8'h00, wd, -1);

        randomAck = 1;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 8; k++) wd[k] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) addr = {$urandom, $urandom};
            else addr = (64'($urandom_range(0, 31)) << 6) | 64'($urandom_range(0, 63));
            typ = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h1;
            applyStimulus(1'($urandom_range(0, 1)), typ, addr, 8'($urandom_range(0, 255)), wd, -1);
        end
        randomAck = 0;

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
